// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider (RISC-V M semantics).
//
// Ports:
//   clk      - single clock, all state on rising edge
//   rst      - synchronous, active-high reset
//   start    - begin an operation (accepted in IDLE or DONE only)
//   op       - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend - operand A, captured on accepted start
//   divisor  - operand B, captured on accepted start
//   busy     - high while iterating (state RUN)
//   done     - one-cycle pulse when result is valid
//   result   - quotient or remainder, held until the next completion
//
// Divide-by-zero and signed overflow bypass the iteration and complete in
// one cycle. All other operations run N restoring iterations on operand
// magnitudes, then fix up signs on the way into the result register.
module div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   rem, rem_n;
  logic [N-1:0]   quo, quo_n;
  logic [N-1:0]   dvs, dvs_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           neg_q, neg_q_n;
  logic           neg_r, neg_r_n;
  logic           sel_rem, sel_rem_n;
  logic [N-1:0]   result_n;
  logic           busy_n, done_n;

  // Start-side decode
  logic           signed_op;
  logic           a_neg, b_neg;
  logic [N-1:0]   abs_a, abs_b;

  // One restoring step
  logic [N:0]     rem_sh, diff;
  logic [N-1:0]   iter_rem, iter_quo;

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & dividend[N-1];
    b_neg     = signed_op & divisor[N-1];
    abs_a     = cond_neg(dividend, a_neg);
    abs_b     = cond_neg(divisor, b_neg);

    // Shifted remainder needs N+1 bits; the difference always fits in
    // N+1 bits two's complement, so its MSB is the restore decision.
    rem_sh    = {rem, quo[N-1]};
    diff      = rem_sh - {1'b0, dvs};
    iter_rem  = diff[N] ? rem_sh[N-1:0] : diff[N-1:0];
    iter_quo  = {quo[N-2:0], ~diff[N]};
  end

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    quo_n     = quo;
    dvs_n     = dvs;
    cnt_n     = cnt;
    neg_q_n   = neg_q;
    neg_r_n   = neg_r;
    sel_rem_n = sel_rem;
    result_n  = result;

    unique case (state)
      RUN: begin
        // start is ignored while iterating
        rem_n = iter_rem;
        quo_n = iter_quo;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_n  = DONE;
          result_n = sel_rem ? cond_neg(iter_rem, neg_r) : cond_neg(iter_quo, neg_q);
        end
      end
      default: begin
        // IDLE and DONE both fall back to IDLE unless a new start lands,
        // which gives back-to-back operation with no bubble from DONE.
        state_n = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_n  = DONE;
            result_n = op[1] ? dividend : '1;
          end else if (signed_op && dividend == {1'b1, {(N-1){1'b0}}} && divisor == '1) begin
            state_n  = DONE;
            result_n = op[1] ? '0 : dividend;
          end else begin
            state_n   = RUN;
            rem_n     = '0;
            quo_n     = abs_a;
            dvs_n     = abs_b;
            cnt_n     = '0;
            neg_q_n   = a_neg ^ b_neg;
            neg_r_n   = a_neg;
            sel_rem_n = op[1];
          end
        end
      end
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= busy_n;
      done    <= done_n;
      result  <= result_n;
      rem     <= rem_n;
      quo     <= quo_n;
      dvs     <= dvs_n;
      cnt     <= cnt_n;
      neg_q   <= neg_q_n;
      neg_r   <= neg_r_n;
      sel_rem <= sel_rem_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed testbench for div_unit (N = 32).
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  div_unit #(.N(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  // Returns at the negedge of cycle 1.
  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // n = number of cycles from the current one up to and including the done
  // cycle. Every cycle before it must show busy=1, done=0.
  task automatic wait_done(input logic [31:0] exp, input int n, input string tag);
    int bad = 0;
    for (int i = 1; i < n; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    if (n > 1) chk({tag, "_busyrun"}, 32'(bad), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd1);
    chk({tag, "_nobusy"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, result, exp);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int stray;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   32'(busy), 32'd0);
    chk("reset_done",   32'(done), 32'd0);
    chk("reset_result", result,    32'd0);
    rst = 1'b0;

    // Unsigned basic: 100/7 -> q 14, r 2, done in cycle 33
    go(OP_DIVU, 32'd100, 32'd7);
    chk("divu_busy_c1", 32'(busy), 32'd1);
    wait_done(32'd14, 33, "divu_100_7");
    after_done("divu_100_7");
    go(OP_REMU, 32'd100, 32'd7);
    wait_done(32'd2, 33, "remu_100_7");
    after_done("remu_100_7");

    // Signed truncation semantics
    go(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(32'hFFFF_FFFD, 33, "div_m7_2");
    after_done("div_m7_2");
    go(OP_REM, 32'hFFFF_FFF9, 32'd2);
    wait_done(32'hFFFF_FFFF, 33, "rem_m7_2");
    after_done("rem_m7_2");
    go(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(32'hFFFF_FFFD, 33, "div_7_m2");
    after_done("div_7_m2");
    go(OP_REM, 32'd7, 32'hFFFF_FFFE);
    wait_done(32'd1, 33, "rem_7_m2");
    after_done("rem_7_m2");
    go(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(32'd14, 33, "div_m100_m7");
    after_done("div_m100_m7");
    go(OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(32'hFFFF_FFFE, 33, "rem_m100_m7");
    after_done("rem_m100_m7");

    // Divide by zero: one-cycle completion, busy never set
    go(OP_DIVU, 32'd5, 32'd0);
    wait_done(32'hFFFF_FFFF, 1, "divu_5_0");
    after_done("divu_5_0");
    go(OP_REMU, 32'd5, 32'd0);
    wait_done(32'd5, 1, "remu_5_0");
    after_done("remu_5_0");
    go(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(32'hFFFF_FFFF, 1, "div_m7_0");
    after_done("div_m7_0");

    // Signed overflow fast path
    go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h8000_0000, 1, "div_ovf");
    after_done("div_ovf");
    go(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'd0, 1, "rem_ovf");
    after_done("rem_ovf");
    // Same operands unsigned must take the iterative path: q 0, r 0x80000000
    go(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h8000_0000, 33, "remu_ovf_ops");
    after_done("remu_ovf_ops");

    // start during RUN is ignored
    go(OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    op       = OP_DIVU;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    start    = 1'b0;
    wait_done(32'd14, 29, "ignore_start");
    after_done("ignore_start");

    // Reset mid-operation aborts it; start during reset is ignored
    go(OP_DIVU, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b0;
    chk("abort_busy",   32'(busy), 32'd0);
    chk("abort_done",   32'(done), 32'd0);
    chk("abort_result", result,    32'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(stray), 32'd0);
    go(OP_DIVU, 32'd9, 32'd3);
    wait_done(32'd3, 33, "divu_9_3");
    after_done("divu_9_3");

    // Back-to-back: new start in the DONE cycle, no idle bubble
    go(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    wait_done(32'hFFFF_FFFF, 33, "b2b_first");
    go(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    chk("b2b_busy_c1", 32'(busy), 32'd1);
    wait_done(32'hFFFF_FFFF, 33, "b2b_second");
    after_done("b2b_second");

    // Fast path straight out of DONE
    go(OP_DIVU, 32'd100, 32'd7);
    wait_done(32'd14, 33, "b2b_fast_a");
    go(OP_REMU, 32'd77, 32'd0);
    wait_done(32'd77, 1, "b2b_fast_b");
    after_done("b2b_fast_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
